fanout_path_router: RTL and testbench

- Sits directly downstream of the FanOut link-element FIFO.
- Consumes that FIFO's forward-token stream (FTk_t) and its grant word, and steers each message to output port A, port B, or both (broadcast).
- Merges the two downstream back-prop streams into a single BTk_t returned upstream.
- Each output port has a one-entry output register, so downstream stalls are absorbed without token loss or duplication.

---
 rtl/fanout_path_router.sv | 225 ++++++++++++++++++++++
 tb/tb_fanout_path_router.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fanout_path_router.sv
// fanout_path_router
// Steers each message leaving the FanOut link-element FIFO to port A, port B
// or both, and merges the two downstream back-prop streams into one upstream.
//
// Ports:
//   clock    : system clock
//   reset    : asynchronous, active-low reset
//   I_FTk    : forward token from the FanOut FIFO (v/a/r used, rest passed through)
//   O_BTk    : back-prop to the FIFO (n = stall, t = terminate, m = OR of selected ports)
//   I_Grt    : path grant, meaningful while I_FTk carries a head token
//   O_FTk_A  : registered forward token to port A
//   I_BTk_A  : back-prop from port A
//   O_FTk_B  : registered forward token to port B
//   I_BTk_B  : back-prop from port B
//   O_Drop   : pulse when a head arrives with no port selected
//   O_Busy   : high while a message is open (forwarding or dropping)

package fanout_path_router_pkg;
    localparam int FTK_DATA_W = 16;
    localparam int BTK_META_W = 4;

    typedef struct packed {
        logic                  v;
        logic                  a;
        logic                  r;
        logic [FTK_DATA_W-1:0] d;
    } FTk_t;

    typedef struct packed {
        logic                  n;
        logic                  t;
        logic [BTK_META_W-1:0] m;
    } BTk_t;
endpackage

module fanout_path_router
    import fanout_path_router_pkg::*;
#(
    parameter int WIDTH_DATA = 32,
    parameter int GRT_BIT_A  = 0,
    parameter int GRT_BIT_B  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  FTk_t                  I_FTk,
    output BTk_t                  O_BTk,
    input  logic [WIDTH_DATA-1:0] I_Grt,
    output FTk_t                  O_FTk_A,
    input  BTk_t                  I_BTk_A,
    output FTk_t                  O_FTk_B,
    input  BTk_t                  I_BTk_B,
    output logic                  O_Drop,
    output logic                  O_Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [1:0] sel_r, sel_nxt_s;
    logic       pend_r, pend_nxt_s;
    logic       done_a_r, done_b_r, done_a_nxt_s, done_b_nxt_s;
    FTk_t       out_a_r, out_b_r;

    logic       start_s, tail_s, first_head_s, route_en_s;
    logic [1:0] grt_sel_s, sel_act_s;
    logic       rdy_a_s, rdy_b_s, load_a_s, load_b_s;
    logic       all_done_s, consume_s, drop_s;
    logic       unused_grt_s;

    // Only the two grant bits steer; the rest are folded so nothing dangles.
    assign unused_grt_s = ^I_Grt;

    // Token classification, effective selection and per-port transfer.
    always_comb begin
        // A single-token message (a=1, r=1) opens and closes in one cycle, so
        // "start" deliberately ignores r.
        start_s      = I_FTk.v & I_FTk.a;
        tail_s       = I_FTk.v & I_FTk.r;
        grt_sel_s    = {I_Grt[GRT_BIT_B], I_Grt[GRT_BIT_A]};
        // pend_r marks a head stalled from an earlier cycle: its grant was
        // already captured in sel_r and must not be resampled.
        first_head_s = (state_r == ST_IDLE) & start_s & ~pend_r;
        route_en_s   = (state_r == ST_FWD) | ((state_r == ST_IDLE) & start_s);
        if (!route_en_s) begin
            sel_act_s = 2'b00;
        end else if (first_head_s) begin
            sel_act_s = grt_sel_s;
        end else begin
            sel_act_s = sel_r;
        end
        rdy_a_s    = ~out_a_r.v | ~I_BTk_A.n;
        rdy_b_s    = ~out_b_r.v | ~I_BTk_B.n;
        load_a_s   = I_FTk.v & sel_act_s[0] & ~done_a_r & rdy_a_s;
        load_b_s   = I_FTk.v & sel_act_s[1] & ~done_b_r & rdy_b_s;
        // An empty selection counts as done, which makes drops and discards
        // consume immediately.
        all_done_s = (~sel_act_s[0] | done_a_r | load_a_s) &
                     (~sel_act_s[1] | done_b_r | load_b_s);
        consume_s  = I_FTk.v & all_done_s;
    end

    // Next state, selection register, pending-head flag, done flags, drop pulse.
    always_comb begin
        state_s      = state_r;
        sel_nxt_s    = sel_r;
        pend_nxt_s   = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (consume_s) begin
                        drop_s = (sel_act_s == 2'b00);
                        if (tail_s) begin
                            sel_nxt_s = 2'b00;
                            state_s   = ST_IDLE;
                        end else if (sel_act_s == 2'b00) begin
                            sel_nxt_s = 2'b00;
                            state_s   = ST_DROP;
                        end else begin
                            sel_nxt_s = sel_act_s;
                            state_s   = ST_FWD;
                        end
                    end else begin
                        sel_nxt_s  = sel_act_s;
                        pend_nxt_s = 1'b1;
                        state_s    = ST_IDLE;
                    end
                end else begin
                    sel_nxt_s = 2'b00;
                    state_s   = ST_IDLE;
                end
            end
            ST_FWD: begin
                if (consume_s & tail_s) begin
                    sel_nxt_s = 2'b00;
                    state_s   = ST_IDLE;
                end else begin
                    sel_nxt_s = sel_r;
                    state_s   = ST_FWD;
                end
            end
            ST_DROP: begin
                if (tail_s) begin
                    sel_nxt_s = 2'b00;
                    state_s   = ST_IDLE;
                end else begin
                    sel_nxt_s = sel_r;
                    state_s   = ST_DROP;
                end
            end
            default: begin
                sel_nxt_s = 2'b00;
                state_s   = ST_IDLE;
            end
        endcase
        // Partial progress on a stalled token is kept until every selected
        // port has it; then both flags clear together.
        if (consume_s) begin
            done_a_nxt_s = 1'b0;
            done_b_nxt_s = 1'b0;
        end else begin
            done_a_nxt_s = done_a_r | load_a_s;
            done_b_nxt_s = done_b_r | load_b_s;
        end
    end

    // Upstream back-prop merge: stall until every selected port has the token.
    always_comb begin
        O_BTk   = '0;
        O_BTk.n = I_FTk.v & ~all_done_s;
        O_BTk.t = (sel_act_s[0] & I_BTk_A.t) | (sel_act_s[1] & I_BTk_B.t);
        O_BTk.m = ({BTK_META_W{sel_act_s[0]}} & I_BTk_A.m) |
                  ({BTK_META_W{sel_act_s[1]}} & I_BTk_B.m);
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            sel_r    <= 2'b00;
            pend_r   <= 1'b0;
            done_a_r <= 1'b0;
            done_b_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            sel_r    <= sel_nxt_s;
            pend_r   <= pend_nxt_s;
            done_a_r <= done_a_nxt_s;
            done_b_r <= done_b_nxt_s;
        end
    end

    // One-entry output registers: load, hold under stall, or drain to empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_a_r <= '0;
            out_b_r <= '0;
        end else begin
            if (load_a_s) begin
                out_a_r <= I_FTk;
            end else if (!I_BTk_A.n) begin
                out_a_r <= '0;
            end else begin
                out_a_r <= out_a_r;
            end
            if (load_b_s) begin
                out_b_r <= I_FTk;
            end else if (!I_BTk_B.n) begin
                out_b_r <= '0;
            end else begin
                out_b_r <= out_b_r;
            end
        end
    end

    assign O_FTk_A = out_a_r;
    assign O_FTk_B = out_b_r;
    assign O_Drop  = drop_s;
    assign O_Busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_fanout_path_router.sv
module tb_fanout_path_router;
    import fanout_path_router_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    FTk_t        ftk;
    BTk_t        btk_up;
    logic [31:0] grt;
    FTk_t        fa, fb;
    BTk_t        bta, btb;
    logic        drop, busy;

    int n_checks = 0;
    int n_errors = 0;

    fanout_path_router #(.WIDTH_DATA(32), .GRT_BIT_A(0), .GRT_BIT_B(1)) dut (
        .clock(clock), .reset(reset), .I_FTk(ftk), .O_BTk(btk_up), .I_Grt(grt),
        .O_FTk_A(fa), .I_BTk_A(bta), .O_FTk_B(fb), .I_BTk_B(btb),
        .O_Drop(drop), .O_Busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v, a, r;
        logic [15:0] d;
        logic [31:0] g;
        logic        an, bn;
        logic        eav;
        logic [15:0] ead;
        logic        ebv;
        logic [15:0] ebd;
        logic        en, edrop, ebusy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic a, logic r, logic [15:0] d, logic [31:0] g,
                                logic an, logic bn, logic eav, logic [15:0] ead,
                                logic ebv, logic [15:0] ebd, logic en, logic edrop, logic ebusy);
        vec_t x;
        x.v = v; x.a = a; x.r = r; x.d = d; x.g = g; x.an = an; x.bn = bn;
        x.eav = eav; x.ead = ead; x.ebv = ebv; x.ebd = ebd;
        x.en = en; x.edrop = edrop; x.ebusy = ebusy;
        return x;
    endfunction

    // ---------------- behavioural reference model ----------------
    // mode: 0 no message open, 1 forwarding, 2 dropping
    int          m_mode;
    bit [1:0]    m_sel;
    bit          m_pend;
    bit          m_done[2];
    FTk_t        m_out[2];
    bit          m_want[2];
    bit          m_load[2];
    bit          m_fin;
    bit          m_drop;
    BTk_t        m_btk;

    task automatic model_reset();
        m_mode = 0; m_sel = 2'b00; m_pend = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_done[p] = 1'b0;
            m_out[p]  = '0;
        end
    endtask

    task automatic model_comb();
        BTk_t bin[2];
        bit   start, routing;
        bin[0] = bta; bin[1] = btb;
        start   = ftk.v && ftk.a;
        routing = (m_mode == 1) || (m_mode == 0 && start);
        m_fin = 1'b1;
        m_btk = '0;
        for (int p = 0; p < 2; p++) begin
            if (!routing)                     m_want[p] = 1'b0;
            else if (m_mode == 0 && !m_pend)  m_want[p] = grt[p];
            else                              m_want[p] = m_sel[p];
            m_load[p] = ftk.v && m_want[p] && !m_done[p] && (!m_out[p].v || !bin[p].n);
            if (m_want[p] && !m_done[p] && !m_load[p]) m_fin = 1'b0;
            if (m_want[p]) begin
                m_btk.t = m_btk.t | bin[p].t;
                m_btk.m = m_btk.m | bin[p].m;
            end
        end
        m_btk.n = ftk.v && !m_fin;
        m_drop  = (m_mode == 0) && start && !m_want[0] && !m_want[1];
    endtask

    task automatic model_seq();
        BTk_t bin[2];
        bit   consume, tail, start;
        bin[0] = bta; bin[1] = btb;
        consume = ftk.v && m_fin;
        tail    = ftk.v && ftk.r;
        start   = ftk.v && ftk.a;
        for (int p = 0; p < 2; p++) begin
            if (m_load[p])       m_out[p] = ftk;
            else if (!bin[p].n)  m_out[p] = '0;
            m_done[p] = consume ? 1'b0 : (m_done[p] || m_load[p]);
        end
        if (m_mode == 0) begin
            if (start && consume) begin
                m_pend = 1'b0;
                if (tail) m_sel = 2'b00;
                else begin
                    m_sel  = {m_want[1], m_want[0]};
                    m_mode = (m_sel == 2'b00) ? 2 : 1;
                end
            end else if (start) begin
                m_sel  = {m_want[1], m_want[0]};
                m_pend = 1'b1;
            end else begin
                m_pend = 1'b0;
            end
        end else if (m_mode == 1) begin
            if (consume && tail) begin m_mode = 0; m_sel = 2'b00; end
        end else begin
            if (tail) m_mode = 0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        FTk_t        cur;
        logic [31:0] cur_grt;
        int          rem;
        logic [15:0] dctr;
        bit          hold;
        int          r, len;

        ftk = '0; grt = 32'd0; bta = '0; btb = '0;
        #2;
        chk("reset_fa", 32'(fa), 32'd0);
        chk("reset_fb", 32'(fb), 32'd0);
        chk("reset_btk", 32'(btk_up), 32'd0);
        chk("reset_drop", 32'(drop), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // unicast A
        tbl.push_back(mk(1,1,0,16'h10,32'h1,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,16'h11,32'h0,0,0, 1,16'h10,0,0, 0,0,1));
        tbl.push_back(mk(1,0,0,16'h12,32'h0,0,0, 1,16'h11,0,0, 0,0,1));
        tbl.push_back(mk(1,0,1,16'h13,32'h0,0,0, 1,16'h12,0,0, 0,0,1));
        tbl.push_back(mk(0,0,0,16'h0,32'h0,0,0, 1,16'h13,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,16'h0,32'h0,0,0, 0,0,0,0, 0,0,0));
        // drop (upper grant bits set, selection bits clear)
        tbl.push_back(mk(1,1,0,16'h20,32'hFFFF_FFFC,0,0, 0,0,0,0, 0,1,0));
        tbl.push_back(mk(1,0,0,16'h21,32'h0,0,0, 0,0,0,0, 0,0,1));
        tbl.push_back(mk(1,0,1,16'h22,32'h0,0,0, 0,0,0,0, 0,0,1));
        tbl.push_back(mk(0,0,0,16'h0,32'h0,0,0, 0,0,0,0, 0,0,0));
        // single-token message to B
        tbl.push_back(mk(1,1,1,16'h30,32'h2,0,0, 0,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,16'h0,32'h0,0,0, 0,0,1,16'h30, 0,0,0));
        tbl.push_back(mk(0,0,0,16'h0,32'h0,0,0, 0,0,0,0, 0,0,0));
        // broadcast with port B stalled
        tbl.push_back(mk(1,1,0,16'h40,32'h3,0,1, 0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,16'h41,32'h0,0,1, 1,16'h40,1,16'h40, 1,0,1));
        tbl.push_back(mk(1,0,0,16'h41,32'h0,0,1, 1,16'h41,1,16'h40, 1,0,1));
        tbl.push_back(mk(1,0,0,16'h41,32'h0,0,0, 0,0,1,16'h40, 0,0,1));
        tbl.push_back(mk(1,0,1,16'h42,32'h0,0,0, 0,0,1,16'h41, 0,0,1));
        tbl.push_back(mk(0,0,0,16'h0,32'h0,0,0, 1,16'h42,1,16'h42, 0,0,0));
        tbl.push_back(mk(0,0,0,16'h0,32'h0,0,0, 0,0,0,0, 0,0,0));
        // port A stalled with register full
        tbl.push_back(mk(1,1,0,16'h50,32'h1,1,0, 0,0,0,0, 0,0,0));
        tbl.push_back(mk(1,0,0,16'h51,32'h0,1,0, 1,16'h50,0,0, 1,0,1));
        tbl.push_back(mk(1,0,0,16'h51,32'h0,1,0, 1,16'h50,0,0, 1,0,1));
        tbl.push_back(mk(1,0,0,16'h51,32'h0,0,0, 1,16'h50,0,0, 0,0,1));
        tbl.push_back(mk(1,0,1,16'h52,32'h0,0,0, 1,16'h51,0,0, 0,0,1));
        tbl.push_back(mk(0,0,0,16'h0,32'h0,0,0, 1,16'h52,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,16'h0,32'h0,0,0, 0,0,0,0, 0,0,0));

        foreach (tbl[i]) begin
            ftk = '0;
            ftk.v = tbl[i].v; ftk.a = tbl[i].a; ftk.r = tbl[i].r; ftk.d = tbl[i].d;
            grt = tbl[i].g;
            bta = '0; bta.n = tbl[i].an;
            btb = '0; btb.n = tbl[i].bn;
            #1;
            chk($sformatf("row%0d_a_v", i), 32'(fa.v), 32'(tbl[i].eav));
            if (tbl[i].eav) chk($sformatf("row%0d_a_d", i), 32'(fa.d), 32'(tbl[i].ead));
            chk($sformatf("row%0d_b_v", i), 32'(fb.v), 32'(tbl[i].ebv));
            if (tbl[i].ebv) chk($sformatf("row%0d_b_d", i), 32'(fb.d), 32'(tbl[i].ebd));
            chk($sformatf("row%0d_n", i), 32'(btk_up.n), 32'(tbl[i].en));
            chk($sformatf("row%0d_drop", i), 32'(drop), 32'(tbl[i].edrop));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].ebusy));
            @(negedge clock);
        end

        // reset in the middle of a forwarded message
        ftk = '0; ftk.v = 1'b1; ftk.a = 1'b1; ftk.d = 16'h60; grt = 32'h1;
        bta = '0; btb = '0;
        @(negedge clock);
        ftk.a = 1'b0; ftk.d = 16'h61; grt = 32'h0;
        #1;
        chk("midrst_pre_busy", 32'(busy), 32'd1);
        chk("midrst_pre_a_v", 32'(fa.v), 32'd1);
        reset = 1'b0;
        #1;
        chk("midrst_a_v", 32'(fa.v), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        ftk = '0;
        @(negedge clock);
        reset = 1'b1;
        ftk.v = 1'b1; ftk.a = 1'b1; ftk.r = 1'b1; ftk.d = 16'h62; grt = 32'h2;
        @(negedge clock);
        ftk = '0; grt = 32'h0;
        #1;
        chk("afresh_b_v", 32'(fb.v), 32'd1);
        chk("afresh_b_d", 32'(fb.d), 32'h62);
        chk("afresh_a_v", 32'(fa.v), 32'd0);
        chk("afresh_busy", 32'(busy), 32'd0);

        // randomized traffic against the reference model
        @(negedge clock);
        reset = 1'b0;
        ftk = '0; bta = '0; btb = '0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        rem = 0; dctr = 16'h100; hold = 1'b0;
        cur = '0; cur_grt = 32'd0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!hold) begin
                cur_grt = $urandom;
                cur = '0;
                if (rem == 0) begin
                    r = $urandom_range(0, 7);
                    if (r < 2) begin
                        cur.d = 16'($urandom);
                    end else if (r == 2) begin
                        cur.v = 1'b1; cur.r = 1'($urandom); cur.d = dctr; dctr++;
                    end else begin
                        len = $urandom_range(1, 4);
                        cur.v = 1'b1; cur.a = 1'b1; cur.r = (len == 1);
                        cur.d = dctr; dctr++;
                        rem = len - 1;
                    end
                end else begin
                    cur.v = 1'b1; cur.r = (rem == 1); cur.d = dctr; dctr++;
                    rem--;
                end
            end
            ftk = cur; grt = cur_grt;
            bta.n = ($urandom_range(0, 2) == 0); bta.t = 1'($urandom); bta.m = 4'($urandom);
            btb.n = ($urandom_range(0, 2) == 0); btb.t = 1'($urandom); btb.m = 4'($urandom);
            #1;
            model_comb();
            chk("rnd_fa", 32'(fa), 32'(m_out[0]));
            chk("rnd_fb", 32'(fb), 32'(m_out[1]));
            chk("rnd_btk", 32'(btk_up), 32'(m_btk));
            chk("rnd_drop", 32'(drop), 32'(m_drop));
            chk("rnd_busy", 32'(busy), 32'(m_mode != 0));
            hold = m_btk.n;
            @(posedge clock);
            model_seq();
            @(negedge clock);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
